cpu_datapath: RTL and testbench
===============================

CPU_DATAPATH -- requirements
Module: cpu_datapath

Interface
REQ-001 Parameter RESET_SP, default 8'hFD, SP value loaded at reset.
REQ-002 Parameter RESET_P, default 8'h34, P value loaded at reset.
REQ-003 clk  input  1  clock; all state captured on rising edge, control strobes change on falling edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 rdy  input  1  1 = advance; 0 = stall all register, PC and flag updates.
REQ-006 rw  input  1  0 = memory read cycle, 1 = memory write cycle.
REQ-007 irxi,iryi,spri,ai,pchi,pcli,psri,iri  input  1 each  load strobes for X,Y,SP,A,PCH,PCL,P,IR from internal bus.
REQ-008 irxo,iryo,spro,ao,pcho,pclo,psro,iro  input  1 each  drive strobes putting X,Y,SP,A,PCH,PCL,P,IR on internal bus.
REQ-009 so  input  1  set-overflow pin, active-low, falling-edge sensitive.
REQ-010 din  input  8  memory read data.
REQ-011 addr  output  16  memory address, continuously {PCH,PCL}.
REQ-012 dout  output  8  memory write data, equals internal bus.
REQ-013 mem_we  output  1  memory write enable, equals rw & rdy.
REQ-014 fetch  output  1  high when pcho & pclo both high (address phase).
REQ-015 ir_q  output  8  current IR contents, feeds the instruction decoder.
REQ-016 p_q  output  8  current P contents.

Function
REQ-017 Eight 8-bit registers X,Y,SP,A,PCH,PCL,P,IR; only change on rising clk when rdy=1, or on reset.
REQ-018 Bus source: pcho&pclo together = address phase, bus = din; else exactly one drive strobe selects that register; none selects din.
REQ-019 Multiple drive strobes outside address phase: fixed priority irxo>iryo>spro>ao>pcho>pclo>psro>iro.
REQ-020 Each asserted load strobe captures the bus value that cycle; several loads may capture the same value simultaneously.
REQ-021 P load forces bit5 to 1; all other bits from bus.
REQ-022 Address phase with rw=0 and rdy=1: {PCH,PCL} increments by 1 at the clock edge; 16'hFFFF wraps to 16'h0000.
REQ-023 PC not incremented when rw=1 or rdy=0.
REQ-024 pchi or pcli in same cycle as an increment: loaded byte takes bus value, other byte keeps its incremented value.
REQ-025 so: two-flop synchronizer plus edge detector; a detected 1->0 transition sets P[6] at next rdy=1 edge; pending set held while rdy=0.
REQ-026 psri and a so set in the same cycle: psri wins, pending set discarded.
REQ-027 rdy=0 mid-instruction: all state frozen, addr, dout, ir_q, p_q stable; mem_we=0.

Reset
REQ-028 rst low asynchronously sets X=Y=A=8'h00, PCH=PCL=8'h00, SP=RESET_SP, P=RESET_P, IR=8'hEA, synchronizer flops to 1.
REQ-029 Reset reached mid-operation aborts any increment or load; first post-reset rising edge behaves as a normal cycle.

Configuration
REQ-030 Macro CPU_DATAPATH_CONTENTION_DETECT_EN defined: extra output bus_err (1 bit), sticky high from the edge after any cycle with rdy=1 and two or more drive strobes outside address phase; cleared only by reset.
REQ-031 Macro undefined: bus_err port absent, priority mux of REQ-019 applies silently, no other behaviour change.

Verification
REQ-032 Reset then idle: addr=16'h0000, SP=8'hFD, p_q=8'h34, ir_q=8'hEA.
REQ-033 PC=16'h00FF, pcho=pclo=1, iri=1, din=8'hA9, rw=0, rdy=1 -> ir_q=8'hA9, addr=16'h0100 next cycle; repeat from 16'hFFFF -> 16'h0000.
REQ-034 din=8'h5A, ai=1 (no drive) then ao=1, irxi=1, iryi=1 -> A=X=Y=8'h5A; ao=1, rw=1 -> dout=8'h5A, mem_we=1, PC unchanged.
REQ-035 rdy=0 during fetch with din=8'h00 -> ir_q and addr unchanged for 3 cycles; rdy=1 -> fetch completes.
REQ-036 so falling edge -> P[6]=1 within 3 cycles; so falling edge coinciding with psri of bus 8'h00 -> p_q=8'h20.
REQ-037 With macro: ao=1, irxo=1, iri=1 -> IR gets X value, bus_err=1 stays high until rst low.

Source files
------------

// File: rtl/cpu_datapath.sv
// 8-bit CPU register file and internal bus: X/Y/SP/A/PC/P/IR, PC auto-increment, SO pin sync.
// Define CPU_DATAPATH_CONTENTION_DETECT_EN to add the sticky bus_err contention output.
module cpu_datapath #(
  parameter logic [7:0] RESET_SP = 8'hFD,
  parameter logic [7:0] RESET_P  = 8'h34
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        rw,
  input  logic        irxi,
  input  logic        iryi,
  input  logic        spri,
  input  logic        ai,
  input  logic        pchi,
  input  logic        pcli,
  input  logic        psri,
  input  logic        iri,
  input  logic        irxo,
  input  logic        iryo,
  input  logic        spro,
  input  logic        ao,
  input  logic        pcho,
  input  logic        pclo,
  input  logic        psro,
  input  logic        iro,
  input  logic        so,
  input  logic [7:0]  din,
  output logic [15:0] addr,
  output logic [7:0]  dout,
  output logic        mem_we,
  output logic        fetch,
  output logic [7:0]  ir_q,
  output logic [7:0]  p_q
`ifdef CPU_DATAPATH_CONTENTION_DETECT_EN
  ,
  output logic        bus_err
`endif
);

  logic [7:0]  x_q, y_q, sp_q, a_q, pch_q, pcl_q;
  logic [7:0]  bus;
  logic        addr_phase, pc_inc;
  logic [15:0] pc_next;
  logic        so_s1, so_s2, so_s3, so_fall, so_pend, so_req;

  assign addr_phase = pcho & pclo;
  assign pc_inc     = addr_phase & ~rw & rdy;
  assign pc_next    = {pch_q, pcl_q} + 16'd1;
  assign so_fall    = so_s3 & ~so_s2;
  assign so_req     = so_fall | so_pend;

  assign addr   = {pch_q, pcl_q};
  assign dout   = bus;
  assign mem_we = rw & rdy;
  assign fetch  = addr_phase;

  always_comb begin
    bus = din;
    if (!addr_phase) begin
      if      (irxo) bus = x_q;
      else if (iryo) bus = y_q;
      else if (spro) bus = sp_q;
      else if (ao)   bus = a_q;
      else if (pcho) bus = pch_q;
      else if (pclo) bus = pcl_q;
      else if (psro) bus = p_q;
      else if (iro)  bus = ir_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q     <= 8'h00;
      y_q     <= 8'h00;
      a_q     <= 8'h00;
      sp_q    <= RESET_SP;
      pch_q   <= 8'h00;
      pcl_q   <= 8'h00;
      p_q     <= RESET_P;
      ir_q    <= 8'hEA;
      so_s1   <= 1'b1;
      so_s2   <= 1'b1;
      so_s3   <= 1'b1;
      so_pend <= 1'b0;
    end else begin
      // Synchronizer runs free so SO edges are caught even while stalled.
      so_s1 <= so;
      so_s2 <= so_s1;
      so_s3 <= so_s2;
      if (rdy) begin
        if (irxi) x_q  <= bus;
        if (iryi) y_q  <= bus;
        if (spri) sp_q <= bus;
        if (ai)   a_q  <= bus;
        if (iri)  ir_q <= bus;
        if (pchi)        pch_q <= bus;
        else if (pc_inc) pch_q <= pc_next[15:8];
        if (pcli)        pcl_q <= bus;
        else if (pc_inc) pcl_q <= pc_next[7:0];
        // A bus load of P overrides and discards any pending SO set.
        if (psri)        p_q <= {bus[7:6], 1'b1, bus[4:0]};
        else if (so_req) p_q <= p_q | 8'h40;
        so_pend <= 1'b0;
      end else begin
        so_pend <= so_req;
      end
    end
  end

`ifdef CPU_DATAPATH_CONTENTION_DETECT_EN
  logic [7:0] drv;
  logic       multi_drv;

  assign drv       = {irxo, iryo, spro, ao, pcho, pclo, psro, iro};
  assign multi_drv = (drv & (drv - 8'd1)) != 8'd0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                bus_err <= 1'b0;
    else if (rdy && !addr_phase && multi_drv) bus_err <= 1'b1;
  end
`else
  // Without contention detection the priority mux resolves multiple drivers silently.
`endif

endmodule

// File: tb/tb_cpu_datapath.sv
// Directed self-checking bench for cpu_datapath; inputs change on the falling edge,
// outputs are checked on the falling edge.
module tb_cpu_datapath;

  logic        clk = 1'b0;
  logic        rst, rdy, rw, so;
  logic        irxi, iryi, spri, ai, pchi, pcli, psri, iri;
  logic        irxo, iryo, spro, ao, pcho, pclo, psro, iro;
  logic [7:0]  din;
  logic [15:0] addr;
  logic [7:0]  dout, ir_q, p_q;
  logic        mem_we, fetch;
`ifdef CPU_DATAPATH_CONTENTION_DETECT_EN
  logic        bus_err;
`endif

  int total = 0;
  int bad   = 0;

  cpu_datapath dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rw(rw),
    .irxi(irxi), .iryi(iryi), .spri(spri), .ai(ai),
    .pchi(pchi), .pcli(pcli), .psri(psri), .iri(iri),
    .irxo(irxo), .iryo(iryo), .spro(spro), .ao(ao),
    .pcho(pcho), .pclo(pclo), .psro(psro), .iro(iro),
    .so(so), .din(din), .addr(addr), .dout(dout), .mem_we(mem_we),
    .fetch(fetch), .ir_q(ir_q), .p_q(p_q)
`ifdef CPU_DATAPATH_CONTENTION_DETECT_EN
    , .bus_err(bus_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clr();
    {irxi, iryi, spri, ai, pchi, pcli, psri, iri} = 8'h00;
    {irxo, iryo, spro, ao, pcho, pclo, psro, iro} = 8'h00;
    rw  = 1'b0;
    rdy = 1'b1;
    din = 8'h00;
  endtask

  initial begin
    clr();
    so  = 1'b1;
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_addr", addr, 16'h0000);
    chk("rst_p", {8'h00, p_q}, 16'h0034);
    chk("rst_ir", {8'h00, ir_q}, 16'h00EA);
    spro = 1'b1; #1;
    chk("rst_sp", {8'h00, dout}, 16'h00FD);
    spro = 1'b0; irxo = 1'b1; #1;
    chk("rst_x", {8'h00, dout}, 16'h0000);
    clr();
    rst = 1'b1;
    tick();
    chk("idle_addr", addr, 16'h0000);

    // Fetch across a page boundary
    pchi = 1'b1; din = 8'h00; tick();
    clr(); pcli = 1'b1; din = 8'hFF; tick();
    clr();
    chk("pc_load", addr, 16'h00FF);
    pcho = 1'b1; pclo = 1'b1; iri = 1'b1; din = 8'hA9; #1;
    chk("fetch_flag", {15'h0, fetch}, 16'h0001);
    chk("fetch_bus", {8'h00, dout}, 16'h00A9);
    tick();
    chk("fetch_ir", {8'h00, ir_q}, 16'h00A9);
    chk("fetch_inc", addr, 16'h0100);

    // Wrap FFFF -> 0000
    clr(); pchi = 1'b1; pcli = 1'b1; din = 8'hFF; tick();
    chk("pc_ffff", addr, 16'hFFFF);
    clr(); pcho = 1'b1; pclo = 1'b1; iri = 1'b1; din = 8'h4C; tick();
    chk("wrap_addr", addr, 16'h0000);
    chk("wrap_ir", {8'h00, ir_q}, 16'h004C);

    // Load of one PC byte during an increment
    clr(); pcli = 1'b1; din = 8'hFF; tick();
    clr(); pcho = 1'b1; pclo = 1'b1; pcli = 1'b1; din = 8'h10; tick();
    chk("inc_plus_load", addr, 16'h0110);

    // Register moves and write cycle
    clr(); ai = 1'b1; din = 8'h5A; tick();
    clr(); ao = 1'b1; irxi = 1'b1; iryi = 1'b1; din = 8'h33; tick();
    clr(); irxo = 1'b1; #1;
    chk("x_val", {8'h00, dout}, 16'h005A);
    clr(); iryo = 1'b1; #1;
    chk("y_val", {8'h00, dout}, 16'h005A);
    clr(); ao = 1'b1; rw = 1'b1; #1;
    chk("wr_dout", {8'h00, dout}, 16'h005A);
    chk("wr_we", {15'h0, mem_we}, 16'h0001);
    tick();
    chk("wr_pc_hold", addr, 16'h0110);
    clr(); pcho = 1'b1; pclo = 1'b1; rw = 1'b1; tick();
    chk("wr_fetch_noinc", addr, 16'h0110);

    // Priority mux and address-phase override
    clr(); irxi = 1'b1; din = 8'h11; tick();
    clr(); iryi = 1'b1; din = 8'h22; tick();
    clr(); irxo = 1'b1; iryo = 1'b1; ao = 1'b1; #1;
    chk("prio_x", {8'h00, dout}, 16'h0011);
    irxo = 1'b0; #1;
    chk("prio_y", {8'h00, dout}, 16'h0022);
    clr(); pcho = 1'b1; pclo = 1'b1; irxo = 1'b1; din = 8'hC3; #1;
    chk("aphase_din", {8'h00, dout}, 16'h00C3);
`ifdef CPU_DATAPATH_CONTENTION_DETECT_EN
    chk("err_clear", {15'h0, bus_err}, 16'h0000);
`endif

    // Stall during fetch
    clr(); pcho = 1'b1; pclo = 1'b1; iri = 1'b1; din = 8'h00; rdy = 1'b0; rw = 1'b1; #1;
    chk("stall_we", {15'h0, mem_we}, 16'h0000);
    rw = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_ir", {8'h00, ir_q}, 16'h004C);
      chk("stall_addr", addr, 16'h0110);
    end
    rdy = 1'b1; tick();
    chk("stall_done_ir", {8'h00, ir_q}, 16'h0000);
    chk("stall_done_addr", addr, 16'h0111);

    // P load forces bit 5
    clr(); psri = 1'b1; din = 8'h00; tick();
    chk("p_load", {8'h00, p_q}, 16'h0020);

    // SO falling edge sets V within 3 cycles
    clr(); so = 1'b0;
    repeat (3) tick();
    chk("so_set", {8'h00, p_q}, 16'h0060);
    so = 1'b1;
    repeat (3) tick();
    chk("so_rise", {8'h00, p_q}, 16'h0060);

    // SO edge coinciding with psri: psri wins, pending discarded
    psri = 1'b1; din = 8'h00; tick();
    clr(); so = 1'b0;
    repeat (2) tick();
    psri = 1'b1; din = 8'h00; tick();
    clr();
    repeat (3) tick();
    chk("so_vs_psri", {8'h00, p_q}, 16'h0020);

    // SO edge during stall is held until rdy
    so = 1'b1;
    repeat (3) tick();
    so = 1'b0; rdy = 1'b0;
    repeat (5) tick();
    chk("so_stall_hold", {8'h00, p_q}, 16'h0020);
    rdy = 1'b1; tick();
    chk("so_stall_apply", {8'h00, p_q}, 16'h0060);
    so = 1'b1;
    repeat (3) tick();

    // Contending drivers: priority gives X to IR
    clr(); ao = 1'b1; irxo = 1'b1; iri = 1'b1; tick();
    clr();
    chk("contend_ir", {8'h00, ir_q}, 16'h0011);
`ifdef CPU_DATAPATH_CONTENTION_DETECT_EN
    chk("err_set", {15'h0, bus_err}, 16'h0001);
    repeat (2) tick();
    chk("err_sticky", {15'h0, bus_err}, 16'h0001);
`endif

    // Asynchronous reset mid-fetch, then a normal first cycle
    pcho = 1'b1; pclo = 1'b1; iri = 1'b1; din = 8'h77;
    #2 rst = 1'b0;
    #1;
    chk("arst_addr", addr, 16'h0000);
    chk("arst_ir", {8'h00, ir_q}, 16'h00EA);
    chk("arst_p", {8'h00, p_q}, 16'h0034);
`ifdef CPU_DATAPATH_CONTENTION_DETECT_EN
    chk("err_rst", {15'h0, bus_err}, 16'h0000);
`endif
    @(negedge clk);
    chk("arst_hold", addr, 16'h0000);
    rst = 1'b1;
    tick();
    chk("post_rst_addr", addr, 16'h0001);
    chk("post_rst_ir", {8'h00, ir_q}, 16'h0077);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
